// File: rtl/cpu_regfile_sb_if.sv
// Bus between issue/writeback and the register file with scoreboard.
// Handshake: there is no valid/ready pair; every input is sampled on each
// rising clk edge and every output is a register that is valid one cycle
// after the addresses that produced it.
interface cpu_regfile_sb_if #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int NREAD = 2,
  parameter int NREGS = 32
);
  logic                    write_enable;
  logic [AW-1:0]           write_addr;
  logic [XLEN-1:0]         write_data;
  logic                    reserve_enable;
  logic [AW-1:0]           reserve_addr;
  logic [NREAD*AW-1:0]     read_addr;
  logic [NREAD*XLEN-1:0]   read_data;
  logic [NREAD-1:0]        read_busy;
  logic [NREGS-1:0]        busy_vec;

  modport master (
    output write_enable, write_addr, write_data,
    output reserve_enable, reserve_addr, read_addr,
    input  read_data, read_busy, busy_vec
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  reserve_enable, reserve_addr, read_addr,
    output read_data, read_busy, busy_vec
  );
endinterface

// File: rtl/cpu_regfile_sb.sv
// Integer register file with NREAD registered read ports, one write port,
// write-first bypass, optional hardwired zero register and a per-register
// busy scoreboard (reserve sets, write clears, reserve wins on a tie).
module cpu_regfile_sb #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  cpu_regfile_sb_if.slave   bus
);
  localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1;
  localparam logic [AW:0] NREGS_LIM = (AW+1)'(NREGS);

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [AW-1:0]         ra [NREAD];
  logic [NREAD*XLEN-1:0] rd_nxt;
  logic [NREAD-1:0]      rb_nxt;
  logic                  wr_ok;
  logic                  rs_ok;

  // An address is usable if it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_LIM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = bus.write_enable   && addr_ok(bus.write_addr);
  assign rs_ok = bus.reserve_enable && addr_ok(bus.reserve_addr);

  for (genvar g = 0; g < NREAD; g++) begin : g_ra
    assign ra[g] = bus.read_addr[g*AW +: AW];
  end

  // Register array: reset clears everything, otherwise commit the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  // Scoreboard: write releases, reserve is applied last so it wins a tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      if (wr_ok) busy_q[bus.write_addr] <= 1'b0;
      if (rs_ok) busy_q[bus.reserve_addr] <= 1'b1;
    end
  end

  // Post-edge view of each read address, including this edge's write/reserve.
  always_comb begin
    rd_nxt = '0;
    rb_nxt = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (addr_ok(ra[i])) begin
        rd_nxt[i*XLEN +: XLEN] = regs[ra[i]];
        rb_nxt[i]              = busy_q[ra[i]];
        if (wr_ok && (bus.write_addr == ra[i])) begin
          rd_nxt[i*XLEN +: XLEN] = bus.write_data;
          rb_nxt[i]              = 1'b0;
        end
        if (rs_ok && (bus.reserve_addr == ra[i])) rb_nxt[i] = 1'b1;
      end
    end
  end

  // Read port output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.read_data <= '0;
      bus.read_busy <= '0;
    end else begin
      bus.read_data <= rd_nxt;
      bus.read_busy <= rb_nxt;
    end
  end

  assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Bench for cpu_regfile_sb: two instances (default 32x64 with zero register,
// and 24-entry / 3-port without zero register) share one stimulus stream and
// are checked against an array-based reference model via an expected queue.
module tb_cpu_regfile_sb;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            re;
  logic [AW-1:0]   rsa;
  logic [AW-1:0]   r0, r1, r2;

  cpu_regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NREAD(2), .NREGS(32)) bus_a ();
  cpu_regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NREAD(3), .NREGS(24)) bus_b ();

  assign bus_a.write_enable   = we;
  assign bus_a.write_addr     = wa;
  assign bus_a.write_data     = wd;
  assign bus_a.reserve_enable = re;
  assign bus_a.reserve_addr   = rsa;
  assign bus_a.read_addr      = {r1, r0};
  assign bus_b.write_enable   = we;
  assign bus_b.write_addr     = wa;
  assign bus_b.write_data     = wd;
  assign bus_b.reserve_enable = re;
  assign bus_b.reserve_addr   = rsa;
  assign bus_b.read_addr      = {r2, r1, r0};

  cpu_regfile_sb #(.XLEN(XLEN), .NREGS(32), .NREAD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  cpu_regfile_sb #(.XLEN(XLEN), .NREGS(24), .NREAD(3), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  // ---------------- reference model ----------------
  int              nregs_m [2] = '{32, 24};
  bit              zero_m  [2] = '{1'b1, 1'b0};
  logic [XLEN-1:0] mem_m   [2][32];
  bit              busy_m  [2][32];

  function automatic bit legal(input int k, input int a);
    return (a < nregs_m[k]) && !(zero_m[k] && a == 0);
  endfunction

  typedef struct packed {
    logic [2*XLEN-1:0] rd_a;
    logic [1:0]        rb_a;
    logic [31:0]       bv_a;
    logic [3*XLEN-1:0] rd_b;
    logic [2:0]        rb_b;
    logic [23:0]       bv_b;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [3*XLEN-1:0] act,
                       input logic [3*XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rn, input bit we_i, input int wa_i,
                       input logic [XLEN-1:0] wd_i, input bit re_i, input int ra_i,
                       input int a0, input int a1, input int a2);
    exp_t e;
    int   adr [3];
    rst = rn; we = we_i; wa = AW'(wa_i); wd = wd_i; re = re_i; rsa = AW'(ra_i);
    r0 = AW'(a0); r1 = AW'(a1); r2 = AW'(a2);
    adr[0] = a0; adr[1] = a1; adr[2] = a2;
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        for (int r = 0; r < 32; r++) begin
          mem_m[k][r]  = '0;
          busy_m[k][r] = 1'b0;
        end
      end else begin
        if (we_i && legal(k, wa_i)) begin
          mem_m[k][wa_i]  = wd_i;
          busy_m[k][wa_i] = 1'b0;
        end
        if (re_i && legal(k, ra_i)) busy_m[k][ra_i] = 1'b1;
      end
    end
    e = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < 2 && legal(0, adr[i])) begin
        e.rd_a[i*XLEN +: XLEN] = mem_m[0][adr[i]];
        e.rb_a[i]              = busy_m[0][adr[i]];
      end
      if (legal(1, adr[i])) begin
        e.rd_b[i*XLEN +: XLEN] = mem_m[1][adr[i]];
        e.rb_b[i]              = busy_m[1][adr[i]];
      end
    end
    for (int r = 0; r < 32; r++) e.bv_a[r] = busy_m[0][r];
    for (int r = 0; r < 24; r++) e.bv_b[r] = busy_m[1][r];
    @(posedge clk);
    exp_q.push_back(e);
    cyc++;
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_read_data", {64'b0, bus_a.read_data}, {64'b0, e.rd_a});
        check("a_read_busy", 192'(bus_a.read_busy), 192'(e.rb_a));
        check("a_busy_vec",  192'(bus_a.busy_vec),  192'(e.bv_a));
        check("b_read_data", bus_b.read_data, e.rd_b);
        check("b_read_busy", 192'(bus_b.read_busy), 192'(e.rb_b));
        check("b_busy_vec",  192'(bus_b.busy_vec),  192'(e.bv_b));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus + report ----------------
  initial begin : stimulus
    // reset held with a write in flight
    drive(0, 1, 5, 64'h1234, 0, 0, 5, 5, 5);
    drive(0, 1, 5, 64'h1234, 1, 5, 5, 5, 5);
    drive(1, 0, 0, 0, 0, 0, 5, 5, 5);
    // write/read bypass and unwritten register
    drive(1, 1, 3, 64'hDEADBEEF_00000001, 0, 0, 3, 4, 3);
    drive(1, 0, 0, 0, 0, 0, 3, 4, 3);
    // scoreboard lifecycle on reg 7
    drive(1, 0, 0, 0, 1, 7, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 7, 7, 7);
    drive(1, 1, 7, 64'h42, 0, 0, 7, 3, 7);
    drive(1, 0, 0, 0, 0, 0, 7, 7, 7);
    // simultaneous write + reserve on reg 9
    drive(1, 1, 9, 64'h11, 1, 9, 9, 9, 9);
    drive(1, 0, 0, 0, 0, 0, 9, 9, 9);
    // register 0: hardwired on instance a, ordinary on instance b
    drive(1, 1, 0, 64'hFF, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // mid-operation reset
    drive(1, 0, 0, 0, 1, 1, 1, 2, 1);
    drive(1, 1, 1, 64'h5, 1, 2, 1, 2, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 2, 1);
    drive(1, 0, 0, 0, 0, 0, 1, 2, 0);
    // out-of-range address on the 24-entry instance
    drive(1, 1, 30, 64'h9, 1, 28, 30, 30, 30);
    drive(1, 0, 0, 0, 0, 0, 30, 28, 30);
    // randomized traffic, narrow address window half the time to force hazards
    for (int n = 0; n < 400; n++) begin
      int hi;
      logic [XLEN-1:0] d;
      hi = ($urandom_range(0, 1) == 0) ? 3 : 31;
      d  = {$urandom(), $urandom()};
      drive(($urandom_range(0, 49) != 0), $urandom_range(0, 1),
            $urandom_range(0, hi), d, ($urandom_range(0, 9) < 4),
            $urandom_range(0, hi), $urandom_range(0, hi),
            $urandom_range(0, hi), $urandom_range(0, hi));
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 2);
    repeat (3) @(negedge clk);
    check("exp_q_drained", 192'(exp_q.size()), 192'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
